// File: rtl/rf_dbg_pkg.sv
// Shared definitions for the register-file debug readout path.
package rf_dbg_pkg;

  // Dump engine sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    DATA,
    CSUM,
    DONE
  } dump_state_e;

  // Register file geometry, shared with the register file itself.
  localparam int unsigned RF_NUM_REGS = 8;
  localparam int unsigned RF_REG_W    = 32;

  // Frame marker sent ahead of the register bytes.
  localparam logic [7:0] DUMP_HEADER = 8'hA5;

endpackage

// File: rtl/rf_dump_ser.sv
// Register-to-byte serializer: holds one register word and presents it
// MSB byte first, with a counter that flags the final byte of the word.
module rf_dump_ser #(
  parameter int unsigned REG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [REG_W-1:0] din,
  output logic [7:0]       byte_out,
  output logic             last
);

  localparam int unsigned BYTES = REG_W / 8;
  localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [REG_W-1:0] shreg;
  logic [CNT_W-1:0] cnt;

  // Word shift register: capture on load, move next byte to the top on shift.
  always_ff @(posedge clk) begin
    if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= shreg << 8;
    end
  end

  // Byte counter within the current word; restarts on every load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (shift) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign byte_out = shreg[REG_W-1 -: 8];
  assign last     = (cnt == CNT_W'(BYTES - 1));

endmodule

// File: rtl/rf_dump_streamer.sv
// Register file dump engine: on start, emits HEADER, every register MSB
// first through a single read port, then an XOR checksum of the data bytes,
// over a byte-wide valid/ready stream.
module rf_dump_streamer
  import rf_dbg_pkg::*;
#(
  parameter int unsigned NUM_REGS = RF_NUM_REGS,
  parameter int unsigned REG_W    = RF_REG_W,
  parameter logic [7:0]  HEADER   = DUMP_HEADER
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic [$clog2(NUM_REGS)-1:0] rd_reg,
  input  logic [REG_W-1:0]            rd_data,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  dump_state_e      state;
  dump_state_e      state_nxt;
  logic [IDX_W-1:0] idx;
  logic [7:0]       checksum;
  logic [7:0]       ser_byte;
  logic             ser_last;
  logic             ser_load;
  logic             ser_shift;
  logic             frame_clr;
  logic             idx_inc;
  logic             idx_clr;
  logic             idx_last;

  assign idx_last = (idx == IDX_W'(NUM_REGS - 1));
  assign rd_reg   = idx;

  rf_dump_ser #(
    .REG_W (REG_W)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (ser_load),
    .shift    (ser_shift),
    .din      (rd_data),
    .byte_out (ser_byte),
    .last     (ser_last)
  );

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, stream outputs and datapath strobes; a byte moves only when
  // tx_ready is seen while tx_valid is up, otherwise everything holds.
  always_comb begin
    state_nxt = state;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    busy      = 1'b0;
    done      = 1'b0;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    frame_clr = 1'b0;
    idx_inc   = 1'b0;
    idx_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          frame_clr = 1'b1;
          state_nxt = HDR;
        end
      end
      HDR: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = HEADER;
        if (tx_ready) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        busy      = 1'b1;
        ser_load  = 1'b1;
        state_nxt = DATA;
      end
      DATA: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = ser_byte;
        if (tx_ready) begin
          ser_shift = 1'b1;
          if (ser_last) begin
            if (idx_last) begin
              state_nxt = CSUM;
            end else begin
              idx_inc   = 1'b1;
              state_nxt = LOAD;
            end
          end
        end
      end
      CSUM: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = checksum;
        if (tx_ready) begin
          idx_clr   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Register index and running checksum of the data bytes already sent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      checksum <= 8'h00;
    end else if (frame_clr) begin
      idx      <= '0;
      checksum <= 8'h00;
    end else begin
      if (ser_shift) begin
        checksum <= checksum ^ ser_byte;
      end
      if (idx_inc) begin
        idx <= idx + IDX_W'(1);
      end else if (idx_clr) begin
        idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rf_dump_streamer.sv
// Bench for rf_dump_streamer: directed scenarios push expected stream bytes
// into a queue; a monitor thread pops and compares on every transfer.
module tb_rf_dump_streamer;

  localparam int NREGS = 8;
  localparam int BPR   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        tx_ready = 1'b0;
  logic [2:0]  rd_reg;
  logic [31:0] rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic        done;

  logic [31:0] regs [NREGS];
  logic [7:0]  exp_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  int done_lat = 0;
  int busy_run = 0;
  int last_busy = 0;
  int d0;
  int s0;

  always #5 clk = ~clk;

  assign rd_data = regs[rd_reg];

  rf_dump_streamer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rd_reg   (rd_reg),
    .rd_data  (rd_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Reference frame from the bench register array, optionally with one
  // register replaced by the value it will hold when it gets sampled.
  task automatic push_frame(input int ov_idx, input logic [31:0] ov_val);
    logic [7:0]  cs;
    logic [31:0] w;
    cs = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < NREGS; i++) begin
      w = (i == ov_idx) ? ov_val : regs[i];
      for (int j = 0; j < BPR; j++) begin
        exp_q.push_back(w[31-8*j -: 8]);
        cs = cs ^ w[31-8*j -: 8];
      end
    end
    exp_q.push_back(cs);
  endtask

  // Hand-written stream for reg1 = 12345678, everything else zero.
  task automatic push_basic_frame;
    exp_q.push_back(8'hA5);
    for (int k = 0; k < 4; k++) exp_q.push_back(8'h00);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    exp_q.push_back(8'h56);
    exp_q.push_back(8'h78);
    for (int k = 0; k < 24; k++) exp_q.push_back(8'h00);
    exp_q.push_back(8'h08);
  endtask

  // Advance until done is seen (returns inside the DONE cycle).
  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) regs[i] = 32'h0;

    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (!rst) begin
          if (start && !busy && !done) begin
            start_cnt++;
            start_cyc = cyc;
            busy_run  = 0;
          end
          if (busy) busy_run++;
          if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL stream_extra: got byte %0h, no byte required", tx_data);
            end else begin
              chk("stream_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
          end
          if (done) begin
            done_cnt++;
            done_lat  = cyc - start_cyc;
            last_busy = busy_run;
          end
        end
      end
    join_none

    // Reset held with random inputs: outputs stay at their reset values.
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
      start    = 1'($urandom);
      tx_ready = 1'($urandom);
      tick();
      chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_rd_reg", {29'd0, rd_reg}, 32'd0);
    end

    // Start in the first cycle after release, random register contents.
    for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
    push_frame(-1, 32'h0);
    tx_ready = 1'b1;
    start    = 1'b1;
    rst      = 1'b0;
    tick();
    start = 1'b0;
    chk("first_hdr_valid", {31'd0, tx_valid}, 32'd1);
    chk("first_hdr_data", {24'd0, tx_data}, 32'hA5);
    wait_done(200);
    tick();
    chk("first_done_latency", done_lat, 43);
    chk("first_drained", exp_q.size(), 0);
    repeat (2) tick();

    // Basic frame with ready held high.
    for (int i = 0; i < NREGS; i++) regs[i] = 32'h0;
    regs[1] = 32'h12345678;
    push_basic_frame();
    d0 = done_cnt;
    pulse_start();
    wait_done(200);
    tick();
    chk("basic_done_latency", done_lat, 43);
    chk("basic_busy_cycles", last_busy, 42);
    chk("basic_done_count", done_cnt - d0, 1);
    chk("basic_drained", exp_q.size(), 0);
    chk("idle_rd_reg", {29'd0, rd_reg}, 32'd0);
    repeat (2) tick();

    // Backpressure: ready low for three cycles while byte 34 is offered.
    push_basic_frame();
    pulse_start();
    repeat (8) tick();
    tx_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_valid", {31'd0, tx_valid}, 32'd1);
      chk("bp_hold_data", {24'd0, tx_data}, 32'h34);
      tick();
    end
    tx_ready = 1'b1;
    chk("bp_release_data", {24'd0, tx_data}, 32'h34);
    wait_done(200);
    tick();
    chk("bp_done_latency", done_lat, 46);
    chk("bp_busy_cycles", last_busy, 45);
    chk("bp_drained", exp_q.size(), 0);
    repeat (2) tick();

    // Core writes reg5 while reg2 is streaming; reg5 is read later.
    push_frame(5, 32'hDEADBEEF);
    pulse_start();
    repeat (13) tick();
    chk("mid_rd_reg", {29'd0, rd_reg}, 32'd2);
    regs[5] = 32'hDEADBEEF;
    wait_done(200);
    tick();
    chk("mid_done_latency", done_lat, 43);
    chk("mid_drained", exp_q.size(), 0);
    repeat (2) tick();

    // Extra start pulses during DATA and during DONE are dropped.
    push_frame(-1, 32'h0);
    s0 = start_cnt;
    d0 = done_cnt;
    pulse_start();
    repeat (4) tick();
    pulse_start();
    wait_done(200);
    pulse_start();
    repeat (50) tick();
    chk("busy_start_frames", start_cnt - s0, 1);
    chk("busy_start_dones", done_cnt - d0, 1);
    chk("busy_start_drained", exp_q.size(), 0);
    chk("busy_start_idle", {31'd0, busy}, 32'd0);

    // Reset during reg3 DATA abandons the frame without a done pulse.
    push_frame(-1, 32'h0);
    d0 = done_cnt;
    pulse_start();
    repeat (18) tick();
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("midrst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_rd_reg", {29'd0, rd_reg}, 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("midrst_no_done", done_cnt - d0, 0);
    regs[3] = 32'hCAFE0123;
    push_frame(-1, 32'h0);
    pulse_start();
    wait_done(200);
    tick();
    chk("postrst_done_latency", done_lat, 43);
    chk("postrst_busy_cycles", last_busy, 42);
    chk("postrst_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
